// File: rtl/pipe_pkg.sv
// Shared pipeline control definitions: bubble codes, PC select codes,
// hazard controller state encodings and the load-use decode helper.
package pipe_pkg;

    typedef logic [1:0] bub_t;

    localparam bub_t BUB_RUN     = 2'd0;
    localparam bub_t BUB_HOLD    = 2'd1;
    localparam bub_t BUB_FLUSH   = 2'd2;
    localparam bub_t BUB_CP0KILL = 2'd3;

    typedef logic [1:0] pcsel_t;

    localparam pcsel_t PC_SEQ = 2'd0;
    localparam pcsel_t PC_EXC = 2'd1;
    localparam pcsel_t PC_EPC = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MD_BUSY   = 2'd1,
        ST_EXC_DRAIN = 2'd2
    } hz_state_e;

    // A load in EX whose destination is read by the instruction in ID.
    // Register 0 is hardwired to zero, so it never creates a dependency.
    function automatic logic load_use_hit(
        input logic       memrd,
        input logic [4:0] rw,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       use_rs,
        input logic       use_rt
    );
        return memrd && (rw != 5'd0) &&
               ((use_rs && (rs == rw)) || (use_rt && (rt == rw)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_sequencer.sv
// Mult/div occupancy tracker: counts the remaining busy cycles of the
// HI/LO owner and reports busy, done and abort for the current cycle.
module md_sequencer
    import pipe_pkg::*;
#(
    parameter int MD_LAT = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    input  hz_state_e i_state,
    input  logic      i_start,
    input  logic      i_kill,
    output logic      o_md_busy,
    output logic      o_md_done,
    output logic      o_md_abort,
    output logic      o_cnt_zero
);

    localparam int CW = $clog2(MD_LAT + 1);

    logic [CW-1:0] r_md_cnt;
    logic          w_active;

    assign w_active   = (i_state == ST_MD_BUSY);
    assign o_cnt_zero = (r_md_cnt == '0);
    assign o_md_busy  = w_active && !i_kill;
    assign o_md_done  = w_active && !i_kill && o_cnt_zero;
    assign o_md_abort = w_active && i_kill;

    // Load the latency on an accepted start, count down while busy, clear on kill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_md_cnt <= '0;
        end else if (i_kill) begin
            r_md_cnt <= '0;
        end else if (i_start) begin
            r_md_cnt <= CW'(MD_LAT - 1);
        end else if (w_active && !o_cnt_zero) begin
            r_md_cnt <= r_md_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline. Decodes load-use
// and HI/LO hazards, tracks exception drain, and drives the bubble code of
// every pipeline register plus the PC redirect select.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_LAT    = 32,
    parameter int DRAIN_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_use_rs,
    input  logic       i_id_use_rt,
    input  logic       i_id_hilo_use,
    input  logic       i_ex_memrd,
    input  logic [4:0] i_ex_rw,
    input  logic       i_ex_md_start,
    input  logic       i_mem_exc,
    input  logic       i_mem_eret,
    output logic [1:0] o_if_bubble,
    output logic [1:0] o_id_bubble,
    output logic [1:0] o_ex_bubble,
    output logic [1:0] o_mem_bubble,
    output logic [1:0] o_wr_bubble,
    output logic [1:0] o_pc_sel,
    output logic       o_md_busy,
    output logic       o_md_done,
    output logic       o_md_abort
);

    localparam int DW = $clog2(DRAIN_CYC + 1);

    hz_state_e     r_state;
    hz_state_e     w_next_state;
    logic [DW-1:0] r_drain_cnt;

    logic w_load_use;
    logic w_hilo_stall;
    logic w_md_start;
    logic w_md_busy;
    logic w_md_done;
    logic w_md_abort;
    logic w_md_cnt_zero;
    logic w_drain_zero;

    assign w_load_use   = load_use_hit(i_ex_memrd, i_ex_rw, i_id_rs, i_id_rt,
                                       i_id_use_rs, i_id_use_rt);
    assign w_hilo_stall = (r_state == ST_MD_BUSY) && i_id_hilo_use;
    assign w_md_start   = i_ex_md_start && !i_mem_exc && !i_mem_eret &&
                          (r_state != ST_EXC_DRAIN);
    assign w_drain_zero = (r_drain_cnt == '0);

    md_sequencer #(
        .MD_LAT (MD_LAT)
    ) u_md_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_state    (r_state),
        .i_start    (w_md_start),
        .i_kill     (i_mem_exc),
        .o_md_busy  (w_md_busy),
        .o_md_done  (w_md_done),
        .o_md_abort (w_md_abort),
        .o_cnt_zero (w_md_cnt_zero)
    );

    // State register; reset discards any running mult/div silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Drain counter: reloaded by every exception, counts down while draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain_cnt <= '0;
        end else if (i_mem_exc) begin
            r_drain_cnt <= DW'(DRAIN_CYC - 1);
        end else if ((r_state == ST_EXC_DRAIN) && !w_drain_zero) begin
            r_drain_cnt <= r_drain_cnt - DW'(1);
        end
    end

    // Next-state logic: exceptions dominate, then mult/div start and completion.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN: begin
                if (i_mem_exc) begin
                    w_next_state = ST_EXC_DRAIN;
                end else if (w_md_start) begin
                    w_next_state = ST_MD_BUSY;
                end
            end
            ST_MD_BUSY: begin
                if (i_mem_exc) begin
                    w_next_state = ST_EXC_DRAIN;
                end else if (w_md_start) begin
                    w_next_state = ST_MD_BUSY;
                end else if (w_md_cnt_zero) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_EXC_DRAIN: begin
                if (i_mem_exc) begin
                    w_next_state = ST_EXC_DRAIN;
                end else if (w_drain_zero) begin
                    w_next_state = ST_RUN;
                end
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    // Priority mux of bubble codes and PC select; everything is quiet in reset.
    always_comb begin
        o_if_bubble  = BUB_RUN;
        o_id_bubble  = BUB_RUN;
        o_ex_bubble  = BUB_RUN;
        o_mem_bubble = BUB_RUN;
        o_wr_bubble  = BUB_RUN;
        o_pc_sel     = PC_SEQ;
        o_md_busy    = 1'b0;
        o_md_done    = 1'b0;
        o_md_abort   = 1'b0;
        if (rst_n) begin
            o_md_busy  = w_md_busy;
            o_md_done  = w_md_done;
            o_md_abort = w_md_abort;
            if (i_mem_exc) begin
                o_if_bubble  = BUB_FLUSH;
                o_id_bubble  = BUB_FLUSH;
                o_ex_bubble  = BUB_FLUSH;
                o_mem_bubble = BUB_FLUSH;
                o_pc_sel     = PC_EXC;
            end else if (r_state == ST_EXC_DRAIN) begin
                o_wr_bubble = BUB_CP0KILL;
            end else if (i_mem_eret) begin
                o_if_bubble = BUB_FLUSH;
                o_id_bubble = BUB_FLUSH;
                o_ex_bubble = BUB_FLUSH;
                o_pc_sel    = PC_EPC;
            end else if (w_hilo_stall || w_load_use) begin
                o_if_bubble = BUB_HOLD;
                o_id_bubble = BUB_FLUSH;
            end
        end
    end

endmodule
